// File: rtl/pixel_upscale_writer_if.sv
// Source-pixel handshake and frame-buffer write port bundle for pixel_upscale_writer.
// slave = the writer block; master = the producer/RAM/control side.
interface pixel_upscale_writer_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              done_pixel;
  logic              done_frame;
  logic              busy;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, wr_addr, wr_data, wr_en, done_pixel, done_frame, busy
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, wr_addr, wr_data, wr_en, done_pixel, done_frame, busy
  );
endinterface

// File: rtl/pixel_upscale_writer.sv
// Writes each source pixel as a 2x2 block into a 2x-upscaled byte frame buffer.
// Define PIXEL_WRITER_WRAP_EN for continuous frames; default is single-shot with a DONE state.
module pixel_upscale_writer #(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pixel_upscale_writer_if.slave bus
);
  localparam int CW = $clog2(SRC_W);
  localparam int RW = $clog2(SRC_H);

  typedef enum logic [2:0] {IDLE, ACCEPT, W0, W1, W2, W3, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     c_q, c_d;
  logic [RW-1:0]     r_q, r_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              done_pixel_q, done_pixel_d;
  logic              done_frame_q, done_frame_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] row;
  logic              last_col, last_px;

  assign row      = ADDR_W'(2 * SRC_W);
  assign base     = ADDR_W'(r_q) * ADDR_W'(4 * SRC_W) + ADDR_W'({c_q, 1'b0});
  assign last_col = (c_q == CW'(SRC_W - 1));
  assign last_px  = last_col && (r_q == RW'(SRC_H - 1));

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    r_d       = r_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = ACCEPT;
        c_d     = '0;
        r_d     = '0;
      end
      ACCEPT: if (bus.in_valid) begin
        state_d   = W0;
        wr_data_d = bus.in_data;
      end
      W0: state_d = W1;
      W1: state_d = W2;
      W2: state_d = W3;
      W3: begin
        if (last_col) begin
          c_d = '0;
          r_d = (r_q == RW'(SRC_H - 1)) ? '0 : r_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
`ifdef PIXEL_WRITER_WRAP_EN
        state_d = ACCEPT;
`else
        state_d = last_px ? DONE : ACCEPT;
`endif
      end
      DONE: if (bus.start) begin
        state_d = ACCEPT;
        c_d     = '0;
        r_d     = '0;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered;
    // counters stay put until W3 leaves, so base is valid for all four writes.
    case (state_d)
      W0:      wr_addr_d = base;
      W1:      wr_addr_d = base + 1'b1;
      W2:      wr_addr_d = base + row;
      W3:      wr_addr_d = base + row + 1'b1;
      default: ;
    endcase
    wr_en_d      = (state_d inside {W0, W1, W2, W3});
    done_pixel_d = (state_d == W3);
    busy_d       = !(state_d inside {IDLE, DONE});
`ifdef PIXEL_WRITER_WRAP_EN
    done_frame_d = (state_d == W3) && last_px;
`else
    done_frame_d = (state_d == DONE);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      c_q          <= '0;
      r_q          <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      done_pixel_q <= 1'b0;
      done_frame_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      c_q          <= c_d;
      r_q          <= r_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      done_pixel_q <= done_pixel_d;
      done_frame_q <= done_frame_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.in_ready   = (state_q == ACCEPT);
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.done_pixel = done_pixel_q;
  assign bus.done_frame = done_frame_q;
  assign bus.busy       = busy_q;
endmodule

// File: doc/pixel_upscale_writer.md
# pixel_upscale_writer

Write-side counterpart of the 2x2 pixel-map reader. Accepts a stream of 8-bit pixels for a 160x120 frame through a valid/ready handshake and writes each pixel four times, as a 2x2 block, into a 320x240 byte-addressed frame buffer over a single write port. It sits between the processing stage and the frame-buffer RAM, and signals per-pixel and per-frame completion to the control FSM.

## Interface
- `SRC_W`, 160, source pixels per row; destination row stride is 2*SRC_W.
- `SRC_H`, 120, source rows per frame.
- `ADDR_W`, 17, frame-buffer address width; must hold 4*SRC_W*SRC_H-1.
- `DATA_W`, 8, pixel width.

- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  begin a frame; sampled in IDLE and DONE only.
- `in_valid`  in  1  `in_data` holds a pixel.
- `in_data`  in  DATA_W  source pixel, raster order.
- `in_ready`  out  1  block can accept a pixel.
- `wr_addr`  out  ADDR_W  frame-buffer write address.
- `wr_data`  out  DATA_W  frame-buffer write data.
- `wr_en`  out  1  write strobe, one RAM write per cycle when high.
- `done_pixel`  out  1  one-cycle pulse on the fourth write of each pixel.
- `done_frame`  out  1  frame complete; see Configuration for pulse vs. level.
- `busy`  out  1  high in every state except IDLE and DONE.

## Operation
- Keep row counter `r` (0..SRC_H-1) and column counter `c` (0..SRC_W-1). No divider.
- Compute `base = r*4*SRC_W + 2*c` from registered counters.
- The four writes of one pixel go to `base`, `base+1`, `base+2*SRC_W`, `base+2*SRC_W+1`, in that order.
- All four writes carry `wr_data` = the captured pixel.
- States:
  - IDLE: on `start`, clear `r`/`c` and go to ACCEPT.
  - ACCEPT: `in_ready`=1. On `in_valid`, capture `in_data` and go to W0.
  - W0, W1, W2, W3: `wr_en`=1, with the address listed above for each state.
  - W3 also pulses `done_pixel` and advances the counters: `c`+1; at `c`=SRC_W-1, `c`=0 and `r`+1.
  - W3 then goes to ACCEPT, except on the last pixel (`r`=SRC_H-1, `c`=SRC_W-1), which goes to DONE.
  - DONE: see Configuration.
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `done_pixel`=0, `done_frame`=0, `busy`=0, state IDLE, `r`=`c`=0.
- `in_valid` is ignored outside ACCEPT; `start` is ignored while busy.
- Reset mid-frame forces `wr_en` low immediately and abandons the partial pixel. No further writes occur.

## Timing
- All outputs are registered except `in_ready`, which is decoded from state (ACCEPT).
- A handshake in cycle k produces writes in cycles k+1..k+4 and `done_pixel` in cycle k+4.
- `in_ready` is high again in cycle k+5. Sustained throughput is 1 pixel per 5 cycles.
- `start` in cycle k gives `in_ready` high in cycle k+1.
- `wr_addr` and `wr_data` are stable for the whole cycle `wr_en` is high, and are don't-care otherwise. They hold their last value.

## Configuration
- `PIXEL_WRITER_WRAP_EN` defined (continuous mode):
  - On the last pixel's W3, `done_frame` pulses for one cycle, coincident with `done_pixel`.
  - The counters clear to 0 and the FSM returns to ACCEPT with no `start` required.
  - DONE is unreachable.
- `PIXEL_WRITER_WRAP_EN` undefined (single-shot mode):
  - The FSM enters DONE after the last pixel's W3.
  - `done_frame` is set high from the cycle after that W3 and holds until `start` or reset.
  - `start` in DONE clears `done_frame`, clears the counters, and goes to ACCEPT.

## Test plan
- Reset, `start`, pixel 0x5A accepted -> writes 0x5A to addresses 0, 1, 320, 321 in 4 consecutive cycles. `done_pixel` is high on the 321 write only.
- Stream pixels 0..161 with `in_valid` held high -> pixel 161 (r=1, c=1) writes to 642, 643, 962, 963. The spacing between handshakes is exactly 5 cycles.
- Full frame of 19200 pixels -> last writes go to 76478, 76479, 76798, 76799.
  - Single-shot: `done_frame` goes high the next cycle and stays high; `in_ready`=0.
  - Continuous: `done_frame` is a 1-cycle pulse, and the next pixel writes address 0.
- Toggle `in_valid` randomly with gaps; assert `in_valid` in IDLE and during W1 -> no pixel is lost or duplicated. Writes occur only for handshaken pixels, in order.
- Assert `rst` during W2 -> `wr_en` drops in the same cycle and all outputs take reset values. After `start`, the next pixel writes address 0.
- Pulse `start` during W1 -> ignored: the counters are not cleared and the write sequence is unchanged.
